// File: rtl/scan_mux.sv
// Scanning channel multiplexer: manual select or timed auto scan with registered outputs.
// Optional SCAN_MUX_MASK_EN adds a per-channel enable port that steers the auto scan.
module scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 8
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [CHANNELS*WIDTH-1:0]     data_in,
  input  logic [$clog2(CHANNELS)-1:0]   sel,
  input  logic                          mode,
  input  logic                          hold,
`ifdef SCAN_MUX_MASK_EN
  input  logic [CHANNELS-1:0]           ch_en,
`endif
  output logic [WIDTH-1:0]              data_out,
  output logic [$clog2(CHANNELS)-1:0]   chan,
  output logic                          valid,
  output logic                          wrap
);

  localparam int CW = $clog2(CHANNELS);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [CW-1:0]       chan_q, chan_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic                valid_q, valid_d;
  logic                mode_q;
  logic [CHANNELS-1:0] en;
  logic                any_en;
  logic [CW-1:0]       nxt_ch;

`ifdef SCAN_MUX_MASK_EN
  assign en = ch_en;
`else
  assign en = '1;
`endif
  assign any_en = |en;

  // Next enabled channel after chan_q in ascending order; highest k first so the nearest wins.
  always_comb begin : find_next
    int unsigned idx;
    nxt_ch = chan_q;
    idx    = 0;
    for (int unsigned k = CHANNELS; k >= 1; k--) begin
      idx = 32'(chan_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (en[CW'(idx)]) nxt_ch = CW'(idx);
    end
  end

  always_comb begin
    chan_d = chan_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (!mode) begin
      if (32'(sel) < CHANNELS) chan_d = sel;
      cnt_d = '0;
    end else if (!mode_q) begin
      cnt_d = '0;
    end else if (!hold) begin
      if (cnt_q == DWELL_LAST) begin
        cnt_d = '0;
        if (any_en) begin
          chan_d = nxt_ch;
          wrap_d = (nxt_ch <= chan_q);
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    data_d  = any_en ? data_in[int'(chan_d)*WIDTH +: WIDTH] : '0;
    valid_d = en[chan_d];
  end

  // mode_q resets high so a scan started out of reset counts immediately instead of
  // treating the first edge as a manual-to-auto switch.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chan_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      mode_q  <= 1'b1;
    end else begin
      chan_q  <= chan_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      mode_q  <= mode;
    end
  end

  assign data_out = data_q;
  assign chan     = chan_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: two instances (4 ch / dwell 8 and 3 ch / dwell 3) share stimulus.
module tb_scan_mux;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] data_in = '0;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  en4 = '1;
  logic [2:0]  en3 = '1;
  logic [3:0]  d4, d3;
  logic [1:0]  c4, c3;
  logic        v4, v3, w4, w3;

  always #5 clock = ~clock;

  scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(8)) dut4 (
    .clock(clock), .resetn(resetn), .data_in(data_in), .sel(sel), .mode(mode), .hold(hold),
`ifdef SCAN_MUX_MASK_EN
    .ch_en(en4),
`endif
    .data_out(d4), .chan(c4), .valid(v4), .wrap(w4)
  );

  scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) dut3 (
    .clock(clock), .resetn(resetn), .data_in(data_in[11:0]), .sel(sel), .mode(mode), .hold(hold),
`ifdef SCAN_MUX_MASK_EN
    .ch_en(en3),
`endif
    .data_out(d3), .chan(c3), .valid(v3), .wrap(w3)
  );

  typedef struct {
    logic [1:0] chan;
    logic [3:0] data;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   m_chan[2];
  int   m_cnt[2];
  bit   m_modeq[2];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_chan[i]  = 0;
      m_cnt[i]   = 0;
      m_modeq[i] = 1'b1;
    end
  endfunction

  // Reference behaviour for one edge of instance i with nch channels and dwell dw.
  function automatic exp_t model_step(int i, int nch, int dw, logic [15:0] en);
    exp_t e;
    bit   any = 1'b0;
    int   nxt = m_chan[i];
    e.wrap = 1'b0;
    for (int k = 0; k < nch; k++) any |= en[k];
    if (!mode) begin
      if (int'(sel) < nch) m_chan[i] = int'(sel);
      m_cnt[i] = 0;
    end else if (!m_modeq[i]) begin
      m_cnt[i] = 0;
    end else if (!hold) begin
      if (m_cnt[i] == dw - 1) begin
        m_cnt[i] = 0;
        if (any) begin
          for (int k = nch; k >= 1; k--)
            if (en[(m_chan[i] + k) % nch]) nxt = (m_chan[i] + k) % nch;
          e.wrap    = (nxt <= m_chan[i]);
          m_chan[i] = nxt;
        end
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_modeq[i] = mode;
    e.chan  = 2'(m_chan[i]);
    e.data  = any ? 4'(data_in >> (4 * m_chan[i])) : 4'h0;
    e.valid = en[m_chan[i]];
    return e;
  endfunction

  task automatic drive(bit md, bit hd, logic [1:0] s, logic [15:0] d);
    @(negedge clock);
    mode    = md;
    hold    = hd;
    sel     = s;
    data_in = d;
    q4.push_back(model_step(0, 4, 8, {12'b0, en4}));
    q3.push_back(model_step(1, 3, 3, {13'b0, en3}));
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_chan4"}, int'(c4), 0);
    chk({tag, "_data4"}, int'(d4), 0);
    chk({tag, "_valid4"}, int'(v4), 0);
    chk({tag, "_wrap4"}, int'(w4), 0);
    chk({tag, "_chan3"}, int'(c3), 0);
    chk({tag, "_data3"}, int'(d3), 0);
    chk({tag, "_valid3"}, int'(v3), 0);
    chk({tag, "_wrap3"}, int'(w3), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #3 resetn = 1'b0;
    #1 check_zero("midreset");
    resetn = 1'b1;
    model_reset();
  endtask

  // Monitor: compares every registered output against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("chan4", int'(c4), int'(e.chan));
        chk("data4", int'(d4), int'(e.data));
        chk("valid4", int'(v4), int'(e.valid));
        chk("wrap4", int'(w4), int'(e.wrap));
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("chan3", int'(c3), int'(e.chan));
        chk("data3", int'(d3), int'(e.data));
        chk("valid3", int'(v3), int'(e.valid));
        chk("wrap3", int'(w3), int'(e.wrap));
      end
    end
  end

  initial begin
    bit md;
    int guard;
    model_reset();
    #2 check_zero("reset");
    @(posedge clock);
    #2 resetn = 1'b1;

    drive(1'b0, 1'b0, 2'd2, 16'h0A00);
    @(posedge clock);
    #2;
    chk("sel2_chan", int'(c4), 2);
    chk("sel2_data", int'(d4), 10);
    chk("sel2_valid", int'(v4), 1);

    for (int n = 0; n < 30; n++)
      drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 16'($urandom));
    for (int n = 0; n < 70; n++)
      drive(1'b1, 1'b0, 2'($urandom), 16'($urandom));
    for (int n = 0; n < 20; n++)
      drive(1'b1, 1'b1, 2'($urandom), 16'($urandom));
    for (int n = 0; n < 30; n++)
      drive(1'b1, 1'b0, 2'($urandom), 16'($urandom));

    md = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      drive(md, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 16'($urandom));
    end

    guard = 0;
    do begin
      drive(1'b1, 1'b0, 2'd0, 16'($urandom));
      guard++;
    end while (!(m_chan[0] == 2 && m_cnt[0] == 3) && guard < 200);
    chk("reach_chan2", int'(guard < 200), 1);
    pulse_reset();
    for (int n = 0; n < 40; n++)
      drive(1'b1, 1'b0, 2'd0, 16'($urandom));

`ifdef SCAN_MUX_MASK_EN
    en4 = 4'b1010;
    for (int n = 0; n < 40; n++)
      drive(1'b1, 1'b0, 2'd0, 16'($urandom));
    en4 = 4'b0000;
    en3 = 3'b000;
    for (int n = 0; n < 10; n++)
      drive(1'b1, 1'b0, 2'd0, 16'($urandom));
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        en4 = 4'($urandom);
        en3 = 3'($urandom);
      end
      if ($urandom_range(0, 19) == 0) md = ~md;
      drive(md, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 16'($urandom));
    end
`endif

    @(posedge clock);
    #2;
    chk("q4_drained", q4.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
